mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  LEGv8 pipelined CPU MEM stage. Sits between the EX/MEM register outputs and the WB stage.
//  Performs data-memory loads/stores through a req/ready handshake and resolves branches (PCSrc).
//  Stalls upstream while an access is outstanding. Contains the MEM/WB pipeline register.
// PARAMETERS
//  DATA_W          64  datapath width (ALU result, store data, load data)
//  REG_W           5   register-index width
//  TIMEOUT_CYCLES  16  ACCESS cycles before abort (used only with DMEM_TIMEOUT_EN)
// PORTS
//  clock               in   1       single clock, all state updates on posedge
//  reset_n             in   1       asynchronous, active-low reset
//  Add_result          in   DATA_W  branch target from EX/MEM
//  Alu_result          in   DATA_W  ALU result / memory byte address
//  Zero                in   1       ALU zero flag
//  Read2               in   DATA_W  store data
//  Write_reg           in   REG_W   destination register
//  Branch, UncBranch   in   1       conditional / unconditional branch
//  Memread, Memwrite   in   1       load / store
//  RegWrite, MemtoReg  in   1       WB controls
//  Instruction_ex_mem  in   32      instruction word (debug)
//  dmem_req            out  1       access request, held until dmem_ready
//  dmem_we             out  1       1 = store
//  dmem_addr           out  DATA_W  doubleword-aligned address
//  dmem_wdata          out  DATA_W  store data
//  dmem_ready          in   1       access complete this cycle
//  dmem_rdata          in   DATA_W  load data, valid when dmem_ready
//  stall               out  1       comb: hold EX/MEM and earlier stages
//  PCSrc               out  1       comb: (Branch & Zero) | UncBranch
//  Branch_target       out  DATA_W  comb: Add_result
//  Read_data_wb        out  DATA_W  MEM/WB: load data
//  Alu_result_wb       out  DATA_W  MEM/WB: ALU result
//  Write_reg_wb        out  REG_W   MEM/WB: destination register
//  RegWrite_wb         out  1       MEM/WB: register write enable
//  MemtoReg_wb         out  1       MEM/WB: WB mux select
//  Instruction_mem_wb  out  32      MEM/WB: instruction (debug)
//  mem_fault           out  1       one-cycle pulse on aborted access
// BEHAVIOUR
//  - Reset (async, reset_n=0): FSM=IDLE; dmem_req/dmem_we=0; dmem_addr/wdata=0; all *_wb=0; mem_fault=0.
//  - FSM states: IDLE, ACCESS.
//  - IDLE, no Memread/Memwrite: stall=0. MEM/WB captures inputs next edge (1-cycle latency).
//    Read_data_wb=0.
//  - IDLE, Memread|Memwrite: stall=1. Next edge -> ACCESS; register dmem_req=1,
//    dmem_we=Memwrite, dmem_addr={Alu_result[63:3],3'b0}, dmem_wdata=Read2.
//    MEM/WB captures a bubble (RegWrite_wb=0).
//  - ACCESS, dmem_ready=0: stall=1; req/addr/wdata held stable; MEM/WB takes a bubble each cycle.
//  - ACCESS, dmem_ready=1: stall=0. Next edge: dmem_req=0, FSM=IDLE.
//    MEM/WB captures inputs with Read_data_wb=dmem_rdata (loads) or 0 (stores).
//  - Minimum memory-op occupancy: 2 cycles (detect + ready in first ACCESS cycle).
//  - Memread & Memwrite both set: treated as a store; Read_data_wb=0.
//  - PCSrc and Branch_target are combinational from the inputs and are never qualified by stall.
//    Branches are not memory ops.
//  - dmem_ready outside ACCESS: ignored.
//  - reset_n low mid-ACCESS: request dropped immediately; the transaction is lost.
// CONFIGURATION
//  DMEM_TIMEOUT_EN defined:
//  - A counter clears on ACCESS entry and counts ACCESS cycles with dmem_ready=0.
//  - On reaching TIMEOUT_CYCLES: stall=0 that cycle. Next edge: dmem_req=0, FSM=IDLE,
//    mem_fault=1 for one cycle, MEM/WB captures the instruction with RegWrite_wb=0.
//  - dmem_ready and the timeout in the same cycle: ready wins, no fault.
//  DMEM_TIMEOUT_EN undefined: no counter; the stage waits indefinitely; mem_fault tied 0.
// STRUCTURE
//  - Shared package legv8_pkg: DATA_W/REG_W constants; mem_state_t {IDLE, ACCESS}.
//  - One sub-module, mem_wb: the MEM/WB register. Async active-low reset.
//    Has a bubble input that zeroes RegWrite/MemtoReg.
//  - FSM, handshake, branch logic and timeout counter stay in mem_stage.
// TESTING
//  1. ALU op, RegWrite=1, Write_reg=3, Alu_result=0x2A
//     -> next edge Alu_result_wb=0x2A, Write_reg_wb=3, RegWrite_wb=1, stall never 1.
//  2. Load, Alu_result=0x100F, ready after 3 ACCESS cycles, rdata=0xDEAD
//     -> dmem_addr=0x1008; stall high 4 cycles; then Read_data_wb=0xDEAD, MemtoReg_wb=1.
//  3. Store, Read2=0x55, ready in first ACCESS cycle
//     -> dmem_we=1, dmem_wdata=0x55, 2-cycle occupancy, RegWrite_wb=0.
//  4. Branch=1,Zero=1,Add_result=0x40 -> PCSrc=1, Branch_target=0x40 same cycle.
//     Branch=1,Zero=0 -> PCSrc=0. UncBranch=1 -> PCSrc=1.
//  5. reset_n low in ACCESS -> dmem_req=0 and all *_wb=0 without a clock edge; FSM=IDLE on release.
//  6. (DMEM_TIMEOUT_EN) load, ready never asserted
//     -> after 16 ACCESS cycles mem_fault pulses 1 cycle, RegWrite_wb=0, stall drops.

Source files
------------

// File: rtl/legv8_pkg.sv
// Shared LEGv8 datapath constants and MEM-stage FSM state type.
package legv8_pkg;

    localparam int DATA_W  = 64;
    localparam int REG_W   = 5;
    localparam int INSTR_W = 32;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_t;

endpackage

// File: rtl/mem_stage_mem_wb.sv
// MEM/WB pipeline register; a bubble squashes the write-back controls.
module mem_wb #(
    parameter int DATA_W = legv8_pkg::DATA_W,
    parameter int REG_W  = legv8_pkg::REG_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              i_bubble,
    input  logic [DATA_W-1:0] i_read_data,
    input  logic [DATA_W-1:0] i_alu_result,
    input  logic [REG_W-1:0]  i_write_reg,
    input  logic              i_reg_write,
    input  logic              i_mem_to_reg,
    input  logic [31:0]       i_instr,
    output logic [DATA_W-1:0] o_read_data,
    output logic [DATA_W-1:0] o_alu_result,
    output logic [REG_W-1:0]  o_write_reg,
    output logic              o_reg_write,
    output logic              o_mem_to_reg,
    output logic [31:0]       o_instr
);

    logic [DATA_W-1:0] r_read_data;
    logic [DATA_W-1:0] r_alu_result;
    logic [REG_W-1:0]  r_write_reg;
    logic              r_reg_write;
    logic              r_mem_to_reg;
    logic [31:0]       r_instr;

    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    // NOTE: every pipeline field is reset so WB never sees stale data after reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_read_data  <= '0;
            r_alu_result <= '0;
            r_write_reg  <= '0;
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_instr      <= '0;
        end else begin
            r_read_data  <= i_read_data;
            r_alu_result <= i_alu_result;
            r_write_reg  <= i_write_reg;
            r_reg_write  <= i_reg_write & ~i_bubble;
            r_mem_to_reg <= i_mem_to_reg & ~i_bubble;
            r_instr      <= i_instr;
        end
    end

    assign o_read_data  = r_read_data;
    assign o_alu_result = r_alu_result;
    assign o_write_reg  = r_write_reg;
    assign o_reg_write  = r_reg_write;
    assign o_mem_to_reg = r_mem_to_reg;
    assign o_instr      = r_instr;

endmodule

// File: rtl/mem_stage.sv
// LEGv8 MEM stage: data-memory handshake FSM, branch resolve, MEM/WB register.
// Optional access timeout with fault pulse when DMEM_TIMEOUT_EN is defined.
module mem_stage #(
    parameter int DATA_W = legv8_pkg::DATA_W,
    parameter int REG_W  = legv8_pkg::REG_W
`ifdef DMEM_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 16
`endif
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] Add_result,
    input  logic [DATA_W-1:0] Alu_result,
    input  logic              Zero,
    input  logic [DATA_W-1:0] Read2,
    input  logic [REG_W-1:0]  Write_reg,
    input  logic              Branch,
    input  logic              UncBranch,
    input  logic              Memread,
    input  logic              Memwrite,
    input  logic              RegWrite,
    input  logic              MemtoReg,
    input  logic [31:0]       Instruction_ex_mem,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ready,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              stall,
    output logic              PCSrc,
    output logic [DATA_W-1:0] Branch_target,
    output logic [DATA_W-1:0] Read_data_wb,
    output logic [DATA_W-1:0] Alu_result_wb,
    output logic [REG_W-1:0]  Write_reg_wb,
    output logic              RegWrite_wb,
    output logic              MemtoReg_wb,
    output logic [31:0]       Instruction_mem_wb,
    output logic              mem_fault
);

    import legv8_pkg::*;

    mem_state_t        r_state;
    mem_state_t        w_next_state;
    logic              r_req;
    logic              r_we;
    logic [DATA_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    logic              w_is_mem;
    logic              w_is_load;
    logic              w_done;
    logic              w_timeout;
    logic              w_end;
    logic              w_bubble;
    logic [DATA_W-1:0] w_read_data;

    assign w_is_mem  = Memread | Memwrite;
    assign w_is_load = Memread & ~Memwrite;     // read+write together is a store
    assign w_done    = (r_state == ACCESS) & dmem_ready;
    assign w_end     = w_done | w_timeout;

`ifdef DMEM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] r_to_cnt;
    logic             r_fault;

    // Counter holds the index of the current ACCESS cycle; ready wins over timeout.
    assign w_timeout = (r_state == ACCESS) & ~dmem_ready
                     & (r_to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_to_cnt <= '0;
            r_fault  <= 1'b0;
        end else begin
            r_fault <= w_timeout;
            if (r_state == IDLE)
                r_to_cnt <= '0;
            else if (!dmem_ready)
                r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign mem_fault = r_fault;
`else
    assign w_timeout = 1'b0;
    assign mem_fault = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_state <= IDLE;
        else
            r_state <= w_next_state;
    end

    // NOTE: defaulting every comb output first prevents latch inference.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_is_mem) w_next_state = ACCESS;
            ACCESS:  if (w_end)    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        stall = 1'b0;
        case (r_state)
            IDLE:    stall = w_is_mem;
            ACCESS:  stall = ~w_end;
            default: stall = 1'b0;
        endcase
    end

    // Request fields are captured on ACCESS entry and held until completion.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if ((r_state == IDLE) && w_is_mem) begin
            r_req   <= 1'b1;
            r_we    <= Memwrite;
            r_addr  <= {Alu_result[DATA_W-1:3], 3'b000};
            r_wdata <= Read2;
        end else if (w_end) begin
            r_req <= 1'b0;
            r_we  <= 1'b0;
        end
    end

    assign dmem_req      = r_req;
    assign dmem_we       = r_we;
    assign dmem_addr     = r_addr;
    assign dmem_wdata    = r_wdata;

    assign PCSrc         = (Branch & Zero) | UncBranch;
    assign Branch_target = Add_result;

    assign w_bubble    = stall | w_timeout;
    assign w_read_data = (w_done & w_is_load) ? dmem_rdata : '0;

    mem_wb #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W)
    ) u_mem_wb (
        .clock        (clock),
        .reset_n      (reset_n),
        .i_bubble     (w_bubble),
        .i_read_data  (w_read_data),
        .i_alu_result (Alu_result),
        .i_write_reg  (Write_reg),
        .i_reg_write  (RegWrite),
        .i_mem_to_reg (MemtoReg),
        .i_instr      (Instruction_ex_mem),
        .o_read_data  (Read_data_wb),
        .o_alu_result (Alu_result_wb),
        .o_write_reg  (Write_reg_wb),
        .o_reg_write  (RegWrite_wb),
        .o_mem_to_reg (MemtoReg_wb),
        .o_instr      (Instruction_mem_wb)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage against a transaction-level model.
module tb_mem_stage;

    localparam int DATA_W = 64;
    localparam int REG_W  = 5;
    localparam int TIMEOUT_CYCLES = 16;

    logic              clock;
    logic              reset_n;
    logic [DATA_W-1:0] Add_result;
    logic [DATA_W-1:0] Alu_result;
    logic              Zero;
    logic [DATA_W-1:0] Read2;
    logic [REG_W-1:0]  Write_reg;
    logic              Branch;
    logic              UncBranch;
    logic              Memread;
    logic              Memwrite;
    logic              RegWrite;
    logic              MemtoReg;
    logic [31:0]       Instruction_ex_mem;
    logic              dmem_req;
    logic              dmem_we;
    logic [DATA_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_ready;
    logic [DATA_W-1:0] dmem_rdata;
    logic              stall;
    logic              PCSrc;
    logic [DATA_W-1:0] Branch_target;
    logic [DATA_W-1:0] Read_data_wb;
    logic [DATA_W-1:0] Alu_result_wb;
    logic [REG_W-1:0]  Write_reg_wb;
    logic              RegWrite_wb;
    logic              MemtoReg_wb;
    logic [31:0]       Instruction_mem_wb;
    logic              mem_fault;

    int n_checks = 0;
    int n_errors = 0;

    mem_stage dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .Add_result         (Add_result),
        .Alu_result         (Alu_result),
        .Zero               (Zero),
        .Read2              (Read2),
        .Write_reg          (Write_reg),
        .Branch             (Branch),
        .UncBranch          (UncBranch),
        .Memread            (Memread),
        .Memwrite           (Memwrite),
        .RegWrite           (RegWrite),
        .MemtoReg           (MemtoReg),
        .Instruction_ex_mem (Instruction_ex_mem),
        .dmem_req           (dmem_req),
        .dmem_we            (dmem_we),
        .dmem_addr          (dmem_addr),
        .dmem_wdata         (dmem_wdata),
        .dmem_ready         (dmem_ready),
        .dmem_rdata         (dmem_rdata),
        .stall              (stall),
        .PCSrc              (PCSrc),
        .Branch_target      (Branch_target),
        .Read_data_wb       (Read_data_wb),
        .Alu_result_wb      (Alu_result_wb),
        .Write_reg_wb       (Write_reg_wb),
        .RegWrite_wb        (RegWrite_wb),
        .MemtoReg_wb        (MemtoReg_wb),
        .Instruction_mem_wb (Instruction_mem_wb),
        .mem_fault          (mem_fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    // One instruction through the stage. Called and returns at posedge+1.
    // delay = number of ACCESS cycles the memory leaves ready low before answering.
    task automatic run_op(input logic rd, input logic wr, input logic rw, input logic m2r,
                          input logic [4:0] wreg, input logic [63:0] alu, input logic [63:0] r2,
                          input logic [63:0] rdata, input int delay, input logic [31:0] instr,
                          input logic br, input logic zr, input logic ub, input logic [63:0] target);
        bit   is_mem;
        bit   abort;
        bit   done;
        int   acc;
        int   cyc;
        int   stalls;
        int   exp_stalls;
        logic [63:0] exp_rdata;

        is_mem = rd | wr;
`ifdef DMEM_TIMEOUT_EN
        abort = is_mem && (delay >= TIMEOUT_CYCLES);
`else
        abort = 1'b0;
`endif
        if (!is_mem)     exp_stalls = 0;
        else if (abort)  exp_stalls = TIMEOUT_CYCLES;
        else             exp_stalls = 1 + delay;
        exp_rdata = (rd && !wr && !abort) ? rdata : 64'h0;

        Memread = rd; Memwrite = wr; RegWrite = rw; MemtoReg = m2r;
        Write_reg = wreg; Alu_result = alu; Read2 = r2; Instruction_ex_mem = instr;
        Branch = br; Zero = zr; UncBranch = ub; Add_result = target;

        done = 0; acc = 0; cyc = 0; stalls = 0;
        while (!done && cyc < 64) begin
            @(negedge clock);
            if (dmem_req) begin
                check("dmem_addr", dmem_addr, alu - (alu % 8));
                check("dmem_we", dmem_we, wr);
                check("dmem_wdata", dmem_wdata, r2);
                dmem_ready = (acc == delay);
                dmem_rdata = dmem_ready ? rdata : rand64();
                acc++;
            end else begin
                dmem_ready = 1'($urandom_range(0, 1));
                dmem_rdata = rand64();
            end
            if (cyc == 0) begin
                check("pcsrc", PCSrc, ub | (br & zr));
                check("branch_target", Branch_target, target);
            end
            #1;
            cyc++;
            if (stall) stalls++;
            else       done = 1;
            @(posedge clock);
            #1;
            dmem_ready = 1'b0;
            if (!done) check("bubble_regwrite", RegWrite_wb, 1'b0);
        end

        check("op_completed", done, 1'b1);
        check("stall_cycles", stalls, exp_stalls);
        check("req_dropped", dmem_req, 1'b0);
        check("alu_result_wb", Alu_result_wb, alu);
        check("write_reg_wb", Write_reg_wb, wreg);
        check("instr_wb", Instruction_mem_wb, instr);
        check("read_data_wb", Read_data_wb, exp_rdata);
        check("regwrite_wb", RegWrite_wb, abort ? 1'b0 : rw);
        check("memtoreg_wb", MemtoReg_wb, abort ? 1'b0 : m2r);
        check("mem_fault", mem_fault, abort);
        if (abort) begin
            Memread = 1'b0; Memwrite = 1'b0;
            @(posedge clock);
            #1;
            check("mem_fault_pulse_end", mem_fault, 1'b0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        Add_result = '0; Alu_result = '0; Zero = 1'b0; Read2 = '0; Write_reg = '0;
        Branch = 1'b0; UncBranch = 1'b0; Memread = 1'b0; Memwrite = 1'b0;
        RegWrite = 1'b0; MemtoReg = 1'b0; Instruction_ex_mem = '0;
        dmem_ready = 1'b0; dmem_rdata = '0;

        #12;
        check("rst_dmem_req", dmem_req, 1'b0);
        check("rst_dmem_we", dmem_we, 1'b0);
        check("rst_dmem_addr", dmem_addr, 64'h0);
        check("rst_dmem_wdata", dmem_wdata, 64'h0);
        check("rst_read_data_wb", Read_data_wb, 64'h0);
        check("rst_alu_result_wb", Alu_result_wb, 64'h0);
        check("rst_write_reg_wb", Write_reg_wb, 0);
        check("rst_regwrite_wb", RegWrite_wb, 1'b0);
        check("rst_memtoreg_wb", MemtoReg_wb, 1'b0);
        check("rst_instr_wb", Instruction_mem_wb, 0);
        check("rst_mem_fault", mem_fault, 1'b0);
        check("rst_stall", stall, 1'b0);

        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Directed scenarios
        run_op(0, 0, 1, 0, 5'd3, 64'h2A, 64'h0, 64'h0, 0, 32'h8B00_0001, 0, 0, 0, 64'h0);
        run_op(1, 0, 1, 1, 5'd9, 64'h100F, 64'h0, 64'hDEAD, 3, 32'hF840_0002, 0, 0, 0, 64'h0);
        run_op(0, 1, 0, 0, 5'd0, 64'h2000, 64'h55, 64'h1234, 0, 32'hF800_0003, 0, 0, 0, 64'h0);
        run_op(1, 1, 1, 0, 5'd7, 64'h3003, 64'h77, 64'hBEEF, 1, 32'hF800_0004, 0, 0, 0, 64'h0);
        run_op(0, 0, 0, 0, 5'd0, 64'h0, 64'h0, 64'h0, 0, 32'hB400_0005, 1, 1, 0, 64'h40);
        run_op(0, 0, 0, 0, 5'd0, 64'h0, 64'h0, 64'h0, 0, 32'hB400_0006, 1, 0, 0, 64'h80);
        run_op(0, 0, 0, 0, 5'd0, 64'h0, 64'h0, 64'h0, 0, 32'h1400_0007, 0, 0, 1, 64'hC0);

        // Reset while a load is outstanding
        run_op(0, 0, 1, 1, 5'd12, 64'h99, 64'h0, 64'h0, 0, 32'h8B00_0008, 0, 0, 0, 64'h0);
        Memread = 1'b1; Memwrite = 1'b0; RegWrite = 1'b1; Alu_result = 64'h4010;
        @(posedge clock);
        #1;
        check("rst_mid_req_before", dmem_req, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_mid_dmem_req", dmem_req, 1'b0);
        check("rst_mid_regwrite_wb", RegWrite_wb, 1'b0);
        check("rst_mid_alu_result_wb", Alu_result_wb, 64'h0);
        check("rst_mid_write_reg_wb", Write_reg_wb, 0);
        check("rst_mid_instr_wb", Instruction_mem_wb, 0);
        Memread = 1'b0; RegWrite = 1'b0;
        #1;
        check("rst_mid_idle_stall", stall, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check("rst_release_req", dmem_req, 1'b0);
        run_op(1, 0, 1, 1, 5'd4, 64'h5008, 64'h0, 64'hCAFE, 2, 32'hF840_0009, 0, 0, 0, 64'h0);

`ifdef DMEM_TIMEOUT_EN
        run_op(1, 0, 1, 1, 5'd6, 64'h6000, 64'h0, 64'hF00D, 1000, 32'hF840_000A, 0, 0, 0, 64'h0);
        run_op(1, 0, 1, 1, 5'd6, 64'h6008, 64'h0, 64'hF00D, TIMEOUT_CYCLES - 1, 32'hF840_000B,
               0, 0, 0, 64'h0);
`endif

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            int   kind;
            int   delay;
            logic rd;
            logic wr;
            kind = $urandom_range(0, 4);
            rd = (kind == 2) || (kind == 4);
            wr = (kind == 3) || (kind == 4);
            delay = $urandom_range(0, 6);
`ifdef DMEM_TIMEOUT_EN
            if ($urandom_range(0, 7) == 0) delay = $urandom_range(14, 20);
`endif
            run_op(rd, wr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 31)), rand64(), rand64(), rand64(), delay, $urandom(),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 3) == 0), rand64());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
